// File: rtl/rip_lsu.sv
// RV32I load/store unit: turns one load/store request into a single word-aligned
// memory access on data port 1, waits out mem_busy, and returns the extended result.
module rip_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [3:0]            mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic       we_q;
    logic [2:0] funct3_q;
    logic [1:0] off_q;
    logic [3:0] mask_q;
    logic       accept;
    logic       bad;

    function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~off[0];
            3'b010:  ok = (off == 2'b00);
            3'b100:  ok = ~we;
            3'b101:  ok = ~we & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                           input logic [DATA_WIDTH-1:0] word);
        logic [DATA_WIDTH-1:0] lane;
        logic [DATA_WIDTH-1:0] r;
        lane = word >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{lane[7]}}, lane[7:0]};
            3'b001:  r = {{16{lane[15]}}, lane[15:0]};
            3'b100:  r = {24'd0, lane[7:0]};
            3'b101:  r = {16'd0, lane[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    assign accept = req_valid & (state == IDLE);
    assign bad    = ~access_ok(req_we, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // ISSUE only leaves once the strobe went out on a non-busy cycle; WAIT's first
    // busy check is therefore always the cycle after the strobe.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bad ? RESP : ISSUE;
            ISSUE:   if (!mem_busy) state_nxt = WAIT;
            WAIT:    if (!mem_busy) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_re     = (state == ISSUE) & ~we_q & ~mem_busy;
        mem_we     = ((state == ISSUE) & we_q & ~mem_busy) ? mask_q : 4'b0000;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q       <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 2'd0;
            mask_q     <= 4'd0;
            mem_addr   <= '0;
            mem_din    <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                funct3_q   <= req_funct3;
                off_q      <= req_addr[1:0];
                mask_q     <= store_mask(req_funct3, req_addr[1:0]);
                mem_addr   <= {req_addr[DATA_WIDTH-1:2], 2'b00};
                mem_din    <= req_wdata << {req_addr[1:0], 3'b000};
                resp_err   <= bad;
                resp_rdata <= '0;
            end
            if (state == WAIT && !mem_busy)
                resp_rdata <= we_q ? '0 : load_extract(funct3_q, off_q, mem_dout);
        end
    end

endmodule

// File: tb/tb_rip_lsu.sv
// Directed bench for rip_lsu with a small word memory that stays busy after each access.
module tb_rip_lsu;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_busy;

    int checks = 0;
    int errors = 0;

    rip_lsu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_busy(mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: samples strobe at the edge, then stays busy for busy_len cycles
    logic [31:0] mem [0:63];
    logic [31:0] dout_q = 32'd0;
    int          busy_cnt = 0;
    int          busy_len = 3;

    always @(posedge clk) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (mem_re) begin
            dout_q   <= mem[mem_addr[7:2]];
            busy_cnt <= busy_len;
        end
        if (mem_we != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_din[8*b +: 8];
            busy_cnt <= busy_len;
        end
    end

    assign mem_busy = (busy_cnt != 0);
    assign mem_dout = dout_q;

    // Results of the most recent do_req
    int          r_lat, r_re_cnt, r_we_cnt, r_viol, r_iss_cyc;
    logic [31:0] r_rd, r_din, r_maddr, r_iss_rd;
    logic        r_err;
    logic [3:0]  r_mask;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE, runs to the response, then one more cycle back to IDLE
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        r_lat = -1; r_re_cnt = 0; r_we_cnt = 0; r_viol = 0; r_iss_cyc = -1;
        r_rd = 32'hDEAD_BEEF; r_err = 1'bx; r_mask = 4'd0; r_din = 32'd0; r_maddr = 32'd0; r_iss_rd = 32'hDEAD_BEEF;
        for (int c = 1; c <= 60 && r_lat < 0; c++) begin
            step();
            req_valid = 1'b0;
            if ((mem_re || mem_we != 4'b0000) && mem_busy) r_viol++;
            if (mem_re) begin r_re_cnt++; r_maddr = mem_addr; r_iss_cyc = c; r_iss_rd = resp_rdata; end
            if (mem_we != 4'b0000) begin
                r_we_cnt++; r_mask = mem_we; r_din = mem_din; r_maddr = mem_addr; r_iss_cyc = c; r_iss_rd = resp_rdata;
            end
            if (resp_valid) begin r_lat = c; r_rd = resp_rdata; r_err = resp_err; end
        end
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got v=%b e=%b exp 0/0", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
        checks++; if (mem_we !== 4'd0 || mem_re !== 1'b0) begin errors++; $display("FAIL reset_strobes got we=%b re=%b exp 0", mem_we, mem_re); end
        checks++; if (mem_addr !== 32'd0 || mem_din !== 32'd0) begin errors++; $display("FAIL reset_mem_bus got a=%h d=%h exp 0", mem_addr, mem_din); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_store_word();
        do_req(1'b1, 3'b010, 32'h10, 32'h8899_AABB);
        checks++; if (r_we_cnt !== 1 || r_re_cnt !== 0) begin errors++; $display("FAIL sw_pulses got we=%0d re=%0d exp 1/0", r_we_cnt, r_re_cnt); end
        checks++; if (r_mask !== 4'b1111 || r_din !== 32'h8899_AABB || r_maddr !== 32'h10) begin
            errors++; $display("FAIL sw_bus got m=%b d=%h a=%h exp 1111/8899aabb/10", r_mask, r_din, r_maddr); end
        checks++; if (r_lat !== 6 || r_err !== 1'b0 || r_rd !== 32'd0) begin
            errors++; $display("FAIL sw_resp got lat=%0d e=%b rd=%h exp 6/0/0", r_lat, r_err, r_rd); end
        do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344);
    endtask

    task automatic test_load_word();
        do_req(1'b0, 3'b010, 32'h10, 32'd0);
        checks++; if (r_re_cnt !== 1 || r_iss_cyc !== 1 || r_maddr !== 32'h10) begin
            errors++; $display("FAIL lw_issue got re=%0d cyc=%0d a=%h exp 1/1/10", r_re_cnt, r_iss_cyc, r_maddr); end
        checks++; if (r_lat !== 6 || r_rd !== 32'h8899_AABB || r_err !== 1'b0) begin
            errors++; $display("FAIL lw_resp got lat=%0d rd=%h e=%b exp 6/8899aabb/0", r_lat, r_rd, r_err); end
        checks++; if (req_ready !== 1'b1 || resp_rdata !== 32'h8899_AABB) begin
            errors++; $display("FAIL lw_hold got rdy=%b rd=%h exp 1/8899aabb", req_ready, resp_rdata); end
    endtask

    task automatic test_load_extend();
        do_req(1'b1, 3'b010, 32'h10, 32'h8012_3456);
        do_req(1'b0, 3'b100, 32'h13, 32'd0);
        checks++; if (r_rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h exp 00000080", r_rd); end
        do_req(1'b0, 3'b000, 32'h13, 32'd0);
        checks++; if (r_rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb got %h exp ffffff80", r_rd); end
        checks++; if (r_iss_rd !== 32'd0) begin errors++; $display("FAIL rdata_clear_on_issue got %h exp 0", r_iss_rd); end
        do_req(1'b0, 3'b001, 32'h12, 32'd0);
        checks++; if (r_rd !== 32'hFFFF_8012) begin errors++; $display("FAIL lh got %h exp ffff8012", r_rd); end
        do_req(1'b0, 3'b101, 32'h12, 32'd0);
        checks++; if (r_rd !== 32'h0000_8012) begin errors++; $display("FAIL lhu got %h exp 00008012", r_rd); end
        do_req(1'b0, 3'b001, 32'h10, 32'd0);
        checks++; if (r_rd !== 32'h0000_3456) begin errors++; $display("FAIL lh_low got %h exp 00003456", r_rd); end
    endtask

    task automatic test_store_sub();
        do_req(1'b1, 3'b000, 32'h22, 32'h0000_00A5);
        checks++; if (r_mask !== 4'b0100 || r_din !== 32'h00A5_0000 || r_maddr !== 32'h20) begin
            errors++; $display("FAIL sb_bus got m=%b d=%h a=%h exp 0100/00a50000/20", r_mask, r_din, r_maddr); end
        checks++; if (r_lat !== 6 || r_rd !== 32'd0 || r_err !== 1'b0) begin
            errors++; $display("FAIL sb_resp got lat=%0d rd=%h e=%b exp 6/0/0", r_lat, r_rd, r_err); end
        do_req(1'b0, 3'b010, 32'h20, 32'd0);
        checks++; if (r_rd !== 32'h11A5_3344) begin errors++; $display("FAIL sb_readback got %h exp 11a53344", r_rd); end
        do_req(1'b1, 3'b001, 32'h22, 32'h1234_BEEF);
        checks++; if (r_mask !== 4'b1100 || r_din !== 32'hBEEF_0000) begin
            errors++; $display("FAIL sh_bus got m=%b d=%h exp 1100/beef0000", r_mask, r_din); end
        do_req(1'b0, 3'b010, 32'h20, 32'd0);
        checks++; if (r_rd !== 32'hBEEF_3344) begin errors++; $display("FAIL sh_readback got %h exp beef3344", r_rd); end
    endtask

    task automatic test_errors();
        logic       we;
        logic [2:0] f3;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       begin we = 1'b1; f3 = 3'b001; a = 32'h21; end
                1:       begin we = 1'b0; f3 = 3'b010; a = 32'h02; end
                2:       begin we = 1'b0; f3 = 3'b011; a = 32'h00; end
                default: begin we = 1'b1; f3 = 3'b100; a = 32'h00; end
            endcase
            do_req(we, f3, a, 32'hFFFF_FFFF);
            checks++; if (r_lat !== 1 || r_err !== 1'b1 || r_rd !== 32'd0) begin
                errors++; $display("FAIL err_resp[%0d] got lat=%0d e=%b rd=%h exp 1/1/0", i, r_lat, r_err, r_rd); end
            checks++; if (r_re_cnt !== 0 || r_we_cnt !== 0) begin
                errors++; $display("FAIL err_no_strobe[%0d] got re=%0d we=%0d exp 0/0", i, r_re_cnt, r_we_cnt); end
            checks++; if (req_ready !== 1'b1 || resp_err !== 1'b1) begin
                errors++; $display("FAIL err_idle[%0d] got rdy=%b err=%b exp 1/1", i, req_ready, resp_err); end
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int re_n = 0;
        int nr = 0;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (req_ready) acc.push_back(i);
            else nr++;
            if (mem_re) re_n++;
            step();
        end
        req_valid = 1'b0;
        checks++; if (acc.size() !== 3) begin errors++; $display("FAIL b2b_accepts got %0d exp 3", acc.size()); end
        else begin
            checks++; if (acc[1] - acc[0] !== 7 || acc[2] - acc[1] !== 7) begin
                errors++; $display("FAIL b2b_spacing got %0d,%0d exp 7,7", acc[1] - acc[0], acc[2] - acc[1]); end
        end
        checks++; if (re_n !== 3 || nr !== 18) begin errors++; $display("FAIL b2b_re_ready got re=%0d notready=%0d exp 3/18", re_n, nr); end
    endtask

    task automatic test_reset_mid();
        busy_len = 8;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL rst_mid_issue got re=%b exp 1", mem_re); end
        step();
        step();
        rstn = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || mem_re !== 1'b0 || mem_we !== 4'd0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ctrl got v=%b re=%b we=%b rdy=%b exp 0/0/0/1", resp_valid, mem_re, mem_we, req_ready); end
        checks++; if (mem_addr !== 32'd0 || mem_din !== 32'd0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_data got a=%h d=%h rd=%h e=%b exp 0", mem_addr, mem_din, resp_rdata, resp_err); end
        step();
        rstn = 1'b1;
        busy_len = 3;
        do_req(1'b0, 3'b010, 32'h10, 32'd0);
        checks++; if (r_viol !== 0 || r_re_cnt !== 1 || r_iss_cyc !== 6) begin
            errors++; $display("FAIL rst_mid_reissue got viol=%0d re=%0d cyc=%0d exp 0/1/6", r_viol, r_re_cnt, r_iss_cyc); end
        checks++; if (r_lat !== 11 || r_rd !== 32'h8012_3456 || r_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_resp got lat=%0d rd=%h e=%b exp 11/80123456/0", r_lat, r_rd, r_err); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_word();
        test_load_extend();
        test_store_sub();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
